// File: rtl/m6809_io_pkg.sv
// Shared constants for the 6809 expansion-card I/O responder: register offsets,
// CTRL bit positions and the wait-state FSM encoding.
package m6809_io_pkg;

  localparam logic [2:0] ADR_CTRL      = 3'd0;
  localparam logic [2:0] ADR_STATUS    = 3'd1;
  localparam logic [2:0] ADR_RELOAD_LO = 3'd2;
  localparam logic [2:0] ADR_RELOAD_HI = 3'd3;
  localparam logic [2:0] ADR_COUNT_LO  = 3'd4;
  localparam logic [2:0] ADR_COUNT_HI  = 3'd5;
  localparam logic [2:0] ADR_VECTOR    = 3'd6;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;

  localparam int WAIT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    STRETCH = 2'b01,
    HOLD    = 2'b10
  } wait_state_e;

endpackage

// File: rtl/m6809_io_timer.sv
// 16-bit E-clock interval timer with FLAG. Build with M6809_IORESP_SNAPSHOT_EN
// to make COUNT_HI reads return the byte captured by the last COUNT_LO read.
module m6809_io_timer (
  input  logic        clkin,
  input  logic        rst_b,
  input  logic        e_fall,
  input  logic        en,
  input  logic        wr_reload_lo,
  input  logic        wr_reload_hi,
  input  logic        clr_flag,
  input  logic        snap_latch,
  input  logic [7:0]  data_in,
  output logic [15:0] reload,
  output logic [15:0] count,
  output logic [7:0]  count_hi_rd,
  output logic        flag
);

  logic underflow;

  assign underflow = e_fall && en && (count == 16'h0000);

  // Underflow set takes priority over any clear arriving on the same E fall.
  always_ff @(posedge clkin or negedge rst_b) begin
    if (!rst_b) begin
      reload <= 16'hFFFF;
      count  <= 16'hFFFF;
      flag   <= 1'b0;
    end else begin
      if (wr_reload_lo) reload[7:0]  <= data_in;
      if (wr_reload_hi) reload[15:8] <= data_in;

      if (wr_reload_hi)
        count <= {data_in, reload[7:0]};
      else if (e_fall && en)
        count <= (count == 16'h0000) ? reload : count - 16'd1;

      if (underflow)
        flag <= 1'b1;
      else if (clr_flag)
        flag <= 1'b0;
    end
  end

`ifdef M6809_IORESP_SNAPSHOT_EN
  logic [7:0] snap;

  always_ff @(posedge clkin or negedge rst_b) begin
    if (!rst_b)
      snap <= 8'h00;
    else if (snap_latch)
      snap <= count[15:8];
  end

  assign count_hi_rd = snap;
`else
  logic unused_snap;

  assign unused_snap = snap_latch;
  assign count_hi_rd = count[15:8];
`endif

endmodule

// File: rtl/m6809_io_responder.sv
// 6809 expansion-card I/O target: register decode, read/IACK data path and
// sys_mrdy wait-state FSM. Optional macro: M6809_IORESP_SNAPSHOT_EN (timer).
//
//   state   | meaning
//   IDLE    | no stretch active, sys_mrdy = 1
//   STRETCH | sys_mrdy held low, counting WAIT_CLKS clkin cycles
//   HOLD    | stretch done, waiting for csio_b to deassert
module m6809_io_responder #(
  parameter int         WAIT_CLKS    = 2,
  parameter logic [7:0] RESET_VECTOR = 8'hF0
) (
  input  logic       clkin,
  input  logic       rst_b,
  input  logic       eclk,
  input  logic       csio_b,
  input  logic       iack_b,
  input  logic       rnw,
  input  logic [2:0] adr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       sys_mrdy,
  output logic       irq_b
);
  import m6809_io_pkg::*;

  logic        e_q, csio_q;
  logic        e_fall, cs_fall, iack_cyc, reg_sel, rd_cond, wr_cyc;
  logic [1:0]  ctrl;
  logic [7:0]  vector, reg_mux, rd_mux, count_hi_rd;
  logic [15:0] reload, count;
  logic        flag;

  wait_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    mrdy_q, mrdy_d;

  assign e_fall   = !eclk && e_q;
  assign cs_fall  = !csio_b && csio_q;
  assign iack_cyc = !iack_b;
  // IACK owns the bus when both selects are low.
  assign reg_sel  = !csio_b && iack_b;
  assign rd_cond  = eclk && (iack_cyc || (reg_sel && rnw));
  assign wr_cyc   = e_fall && reg_sel && !rnw;

  always_ff @(posedge clkin or negedge rst_b) begin
    if (!rst_b) begin
      e_q    <= 1'b0;
      csio_q <= 1'b1;
      ctrl   <= 2'b00;
      vector <= RESET_VECTOR;
    end else begin
      e_q    <= eclk;
      csio_q <= csio_b;
      if (wr_cyc && adr == ADR_CTRL)   ctrl   <= data_in[1:0];
      if (wr_cyc && adr == ADR_VECTOR) vector <= data_in;
    end
  end

  m6809_io_timer u_timer (
    .clkin        (clkin),
    .rst_b        (rst_b),
    .e_fall       (e_fall),
    .en           (ctrl[CTRL_EN]),
    .wr_reload_lo (wr_cyc && adr == ADR_RELOAD_LO),
    .wr_reload_hi (wr_cyc && adr == ADR_RELOAD_HI),
    .clr_flag     ((wr_cyc && adr == ADR_STATUS && data_in[0]) || (e_fall && iack_cyc)),
    .snap_latch   (e_fall && reg_sel && rnw && adr == ADR_COUNT_LO),
    .data_in      (data_in),
    .reload       (reload),
    .count        (count),
    .count_hi_rd  (count_hi_rd),
    .flag         (flag)
  );

  always_comb begin
    reg_mux = 8'h00;
    case (adr)
      ADR_CTRL:      reg_mux = {6'b0, ctrl};
      ADR_STATUS:    reg_mux = {7'b0, flag};
      ADR_RELOAD_LO: reg_mux = reload[7:0];
      ADR_RELOAD_HI: reg_mux = reload[15:8];
      ADR_COUNT_LO:  reg_mux = count[7:0];
      ADR_COUNT_HI:  reg_mux = count_hi_rd;
      ADR_VECTOR:    reg_mux = vector;
      default:       reg_mux = 8'h00;
    endcase
  end

  assign rd_mux = iack_cyc ? vector : reg_mux;

  always_ff @(posedge clkin or negedge rst_b) begin
    if (!rst_b) begin
      data_out <= 8'h00;
      data_oe  <= 1'b0;
      irq_b    <= 1'b1;
    end else begin
      data_oe  <= rd_cond;
      data_out <= rd_cond ? rd_mux : 8'h00;
      irq_b    <= !(flag && ctrl[CTRL_IE]);
    end
  end

  always_ff @(posedge clkin or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mrdy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mrdy_q  <= mrdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mrdy_d  = mrdy_q;
    case (state_q)
      IDLE: begin
        if (cs_fall && !eclk && iack_b && (WAIT_CLKS != 0)) begin
          state_d = STRETCH;
          cnt_d   = WAIT_CNT_W'(WAIT_CLKS);
          mrdy_d  = 1'b0;
        end
      end
      STRETCH: begin
        if (csio_b) begin
          state_d = IDLE;
          mrdy_d  = 1'b1;
        end else if (cnt_q <= WAIT_CNT_W'(1)) begin
          state_d = HOLD;
          mrdy_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      HOLD: begin
        if (csio_b) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        mrdy_d  = 1'b1;
      end
    endcase
  end

  assign sys_mrdy = mrdy_q;

endmodule

// File: tb/tb_m6809_io_responder.sv
// Self-checking bench for m6809_io_responder: E-cycle bus transactions compared
// against a per-cycle register/timer model; honours M6809_IORESP_SNAPSHOT_EN.
module tb_m6809_io_responder;
  import m6809_io_pkg::*;

  localparam int WAIT_CLKS = 2;

  logic       clkin = 1'b0;
  logic       rst_b = 1'b0;
  logic       eclk = 1'b0;
  logic       csio_b = 1'b1;
  logic       iack_b = 1'b1;
  logic       rnw = 1'b1;
  logic [2:0] adr = 3'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out, unused_dout0;
  logic       data_oe, sys_mrdy, irq_b;
  logic       unused_oe0, sys_mrdy0, unused_irq0;

  int checks = 0;
  int errors = 0;

  always #5 clkin = ~clkin;

  m6809_io_responder #(.WAIT_CLKS(WAIT_CLKS), .RESET_VECTOR(8'hF0)) dut (
    .clkin(clkin), .rst_b(rst_b), .eclk(eclk), .csio_b(csio_b), .iack_b(iack_b),
    .rnw(rnw), .adr(adr), .data_in(data_in), .data_out(data_out),
    .data_oe(data_oe), .sys_mrdy(sys_mrdy), .irq_b(irq_b)
  );

  m6809_io_responder #(.WAIT_CLKS(0), .RESET_VECTOR(8'hF0)) dut0 (
    .clkin(clkin), .rst_b(rst_b), .eclk(eclk), .csio_b(csio_b), .iack_b(iack_b),
    .rnw(rnw), .adr(adr), .data_in(data_in), .data_out(unused_dout0),
    .data_oe(unused_oe0), .sys_mrdy(sys_mrdy0), .irq_b(unused_irq0)
  );

  // reference model state, one update per E cycle
  logic [1:0]  m_ctrl;
  logic        m_flag;
  logic [15:0] m_reload, m_count;
  logic [7:0]  m_vector;
`ifdef M6809_IORESP_SNAPSHOT_EN
  logic [7:0]  m_snap;
`endif
  logic        prev_cs_b;

  logic       exp_irq, exp_oe;
  logic [7:0] exp_dout;
  int         exp_mrdy_low;
  logic       obs_irq, obs_oe_idle, obs_oe;
  logic [7:0] obs_dout;
  int         obs_mrdy_low, obs_mrdy0_low;

  task automatic model_reset();
    m_ctrl = 2'b00; m_flag = 1'b0; m_reload = 16'hFFFF; m_count = 16'hFFFF;
    m_vector = 8'hF0; prev_cs_b = 1'b1;
`ifdef M6809_IORESP_SNAPSHOT_EN
    m_snap = 8'h00;
`endif
  endtask

  function automatic logic [7:0] model_reg(input logic [2:0] a);
    case (a)
      3'd0: return {6'b0, m_ctrl};
      3'd1: return {7'b0, m_flag};
      3'd2: return m_reload[7:0];
      3'd3: return m_reload[15:8];
      3'd4: return m_count[7:0];
`ifdef M6809_IORESP_SNAPSHOT_EN
      3'd5: return m_snap;
`else
      3'd5: return m_count[15:8];
`endif
      3'd6: return m_vector;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_update(input logic cs, input logic ia, input logic rw,
                              input logic [2:0] a, input logic [7:0] d);
    logic uf, wr, clr;
    uf  = m_ctrl[0] && (m_count == 16'h0000);
    wr  = !cs && ia && !rw;
    clr = !ia || (wr && a == 3'd1 && d[0]);
`ifdef M6809_IORESP_SNAPSHOT_EN
    if (!cs && ia && rw && a == 3'd4) m_snap = m_count[15:8];
`endif
    if (wr && a == 3'd3)  m_count = {d, m_reload[7:0]};
    else if (m_ctrl[0])   m_count = uf ? m_reload : m_count - 16'd1;
    if (uf)       m_flag = 1'b1;
    else if (clr) m_flag = 1'b0;
    if (wr) begin
      case (a)
        3'd0: m_ctrl = d[1:0];
        3'd2: m_reload[7:0] = d;
        3'd3: m_reload[15:8] = d;
        3'd6: m_vector = d;
        default: ;
      endcase
    end
    prev_cs_b = cs;
  endtask

  // One E cycle = 4 clkin: 2 low (bus set up), 2 high; E falls at the end.
  task automatic bus_cycle(input logic cs, input logic ia, input logic rw,
                           input logic [2:0] a, input logic [7:0] d);
    exp_irq      = !(m_flag && m_ctrl[1]);
    exp_oe       = !ia || (!cs && rw);
    exp_dout     = !ia ? m_vector : model_reg(a);
    exp_mrdy_low = (!cs && ia && prev_cs_b) ? WAIT_CLKS : 0;
    obs_mrdy_low = 0; obs_mrdy0_low = 0;
    @(negedge clkin);
    csio_b = cs; iack_b = ia; rnw = rw; adr = a; data_in = d;
    @(negedge clkin);
    obs_irq = irq_b; obs_oe_idle = data_oe;
    if (!sys_mrdy) obs_mrdy_low++;
    if (!sys_mrdy0) obs_mrdy0_low++;
    eclk = 1'b1;
    @(negedge clkin);
    obs_oe = data_oe; obs_dout = data_out;
    if (!sys_mrdy) obs_mrdy_low++;
    if (!sys_mrdy0) obs_mrdy0_low++;
    @(negedge clkin);
    if (!sys_mrdy) obs_mrdy_low++;
    if (!sys_mrdy0) obs_mrdy0_low++;
    eclk = 1'b0;
    model_update(cs, ia, rw, a, d);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clkin);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data_out got %h exp 00", data_out); end
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL rst_data_oe got %b exp 0", data_oe); end
    checks++; if (sys_mrdy !== 1'b1) begin errors++; $display("FAIL rst_sys_mrdy got %b exp 1", sys_mrdy); end
    checks++; if (irq_b !== 1'b1) begin errors++; $display("FAIL rst_irq_b got %b exp 1", irq_b); end
    rst_b = 1'b1;
    model_reset();
    // start a CTRL write, let the stretch begin, then reset mid-access
    @(negedge clkin);
    csio_b = 1'b0; rnw = 1'b0; adr = ADR_CTRL; data_in = 8'hFF;
    @(negedge clkin);
    rst_b = 1'b0;
    #1;
    checks++; if (sys_mrdy !== 1'b1) begin errors++; $display("FAIL midrst_sys_mrdy got %b exp 1", sys_mrdy); end
    checks++; if (data_oe !== 1'b0 || data_out !== 8'h00) begin errors++; $display("FAIL midrst_data got oe=%b d=%h exp oe=0 d=00", data_oe, data_out); end
    eclk = 1'b1;
    @(negedge clkin);
    eclk = 1'b0;
    @(negedge clkin);
    csio_b = 1'b1; rnw = 1'b1;
    @(negedge clkin);
    rst_b = 1'b1;
    model_reset();
    bus_cycle(1'b0, 1'b1, 1'b1, ADR_CTRL, 8'h00);
    checks++; if (obs_dout !== 8'h00) begin errors++; $display("FAIL rst_ctrl got %h exp 00", obs_dout); end
    bus_cycle(1'b0, 1'b1, 1'b1, ADR_VECTOR, 8'h00);
    checks++; if (obs_dout !== 8'hF0) begin errors++; $display("FAIL rst_vector got %h exp f0", obs_dout); end
    bus_cycle(1'b1, 1'b1, 1'b1, 3'd0, 8'h00);
    bus_cycle(1'b0, 1'b1, 1'b0, ADR_CTRL, 8'h02);
    bus_cycle(1'b0, 1'b1, 1'b1, ADR_CTRL, 8'h00);
    checks++; if (obs_dout !== 8'h02) begin errors++; $display("FAIL post_rst_write got %h exp 02", obs_dout); end
  endtask

  task automatic test_timer();
    bus_cycle(1'b0, 1'b1, 1'b0, ADR_CTRL, 8'h00);
    bus_cycle(1'b0, 1'b1, 1'b0, ADR_RELOAD_LO, 8'h03);
    bus_cycle(1'b0, 1'b1, 1'b0, ADR_RELOAD_HI, 8'h00);
    bus_cycle(1'b0, 1'b1, 1'b0, ADR_CTRL, 8'h03);
    for (int k = 1; k <= 6; k++) begin
      bus_cycle(1'b1, 1'b1, 1'b1, 3'd0, 8'h00);
      checks++;
      if (obs_irq !== ((k <= 4) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL timer_irq cycle %0d got %b exp %b", k, obs_irq, (k <= 4));
      end
    end
    for (int k = 0; k < 8; k++) begin
      bus_cycle(1'b0, 1'b1, 1'b1, ADR_COUNT_LO, 8'h00);
      checks++; if (obs_dout !== exp_dout) begin errors++; $display("FAIL timer_count_lo got %h exp %h", obs_dout, exp_dout); end
    end
  endtask

  task automatic test_iack();
    bus_cycle(1'b0, 1'b1, 1'b0, ADR_VECTOR, 8'h5A);
    bus_cycle(1'b0, 1'b1, 1'b0, ADR_CTRL, 8'h02);
    bus_cycle(1'b1, 1'b0, 1'b1, 3'd0, 8'h00);
    checks++; if (obs_irq !== 1'b0) begin errors++; $display("FAIL iack_irq_before got %b exp 0", obs_irq); end
    checks++; if (obs_oe !== 1'b1) begin errors++; $display("FAIL iack_oe got %b exp 1", obs_oe); end
    checks++; if (obs_dout !== 8'h5A) begin errors++; $display("FAIL iack_vector got %h exp 5a", obs_dout); end
    checks++; if (obs_mrdy_low !== 0) begin errors++; $display("FAIL iack_no_stretch got %0d exp 0", obs_mrdy_low); end
    bus_cycle(1'b1, 1'b1, 1'b1, 3'd0, 8'h00);
    checks++; if (obs_irq !== 1'b1) begin errors++; $display("FAIL iack_irq_after got %b exp 1", obs_irq); end
  endtask

  task automatic test_collision();
    bus_cycle(1'b0, 1'b1, 1'b0, ADR_CTRL, 8'h03);
    for (int i = 0; i < 20 && m_count != 16'h0000; i++)
      bus_cycle(1'b1, 1'b1, 1'b1, 3'd0, 8'h00);
    bus_cycle(1'b0, 1'b1, 1'b0, ADR_STATUS, 8'h01);
    bus_cycle(1'b1, 1'b1, 1'b1, 3'd0, 8'h00);
    checks++; if (obs_irq !== 1'b0) begin errors++; $display("FAIL collide_irq got %b exp 0", obs_irq); end
    bus_cycle(1'b0, 1'b1, 1'b1, ADR_STATUS, 8'h00);
    checks++; if (obs_dout !== 8'h01) begin errors++; $display("FAIL collide_flag got %h exp 01", obs_dout); end
    bus_cycle(1'b0, 1'b1, 1'b0, ADR_STATUS, 8'h01);
    bus_cycle(1'b0, 1'b1, 1'b1, ADR_STATUS, 8'h00);
    checks++; if (obs_dout !== 8'h00) begin errors++; $display("FAIL status_clear got %h exp 00", obs_dout); end
  endtask

  task automatic test_wait();
    bus_cycle(1'b0, 1'b1, 1'b0, ADR_CTRL, 8'h00);
    bus_cycle(1'b1, 1'b1, 1'b1, 3'd0, 8'h00);
    bus_cycle(1'b0, 1'b1, 1'b1, ADR_CTRL, 8'h00);
    checks++; if (obs_mrdy_low !== 2) begin errors++; $display("FAIL wait_stretch got %0d exp 2", obs_mrdy_low); end
    checks++; if (obs_mrdy0_low !== 0) begin errors++; $display("FAIL wait0_stretch got %0d exp 0", obs_mrdy0_low); end
    bus_cycle(1'b0, 1'b1, 1'b1, ADR_VECTOR, 8'h00);
    checks++; if (obs_mrdy_low !== 0) begin errors++; $display("FAIL wait_b2b got %0d exp 0", obs_mrdy_low); end
    bus_cycle(1'b1, 1'b1, 1'b1, 3'd0, 8'h00);
    bus_cycle(1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
    checks++; if (obs_mrdy_low !== 0) begin errors++; $display("FAIL wait_iack got %0d exp 0", obs_mrdy_low); end
  endtask

  task automatic test_snapshot();
    logic [7:0] exp_hi;
`ifdef M6809_IORESP_SNAPSHOT_EN
    exp_hi = 8'h01;
`else
    exp_hi = 8'h00;
`endif
    bus_cycle(1'b0, 1'b1, 1'b0, ADR_CTRL, 8'h00);
    bus_cycle(1'b0, 1'b1, 1'b0, ADR_RELOAD_LO, 8'hFF);
    bus_cycle(1'b0, 1'b1, 1'b0, ADR_RELOAD_HI, 8'h01);
    bus_cycle(1'b0, 1'b1, 1'b0, ADR_CTRL, 8'h01);
    bus_cycle(1'b0, 1'b1, 1'b1, ADR_COUNT_LO, 8'h00);
    checks++; if (obs_dout !== 8'hFF) begin errors++; $display("FAIL snap_count_lo got %h exp ff", obs_dout); end
    repeat (256) bus_cycle(1'b1, 1'b1, 1'b1, 3'd0, 8'h00);
    bus_cycle(1'b0, 1'b1, 1'b1, ADR_COUNT_HI, 8'h00);
    checks++; if (obs_dout !== exp_hi) begin errors++; $display("FAIL snap_count_hi got %h exp %h", obs_dout, exp_hi); end
    bus_cycle(1'b0, 1'b1, 1'b1, ADR_COUNT_LO, 8'h00);
    checks++; if (obs_dout !== 8'hFD) begin errors++; $display("FAIL snap_count_lo2 got %h exp fd", obs_dout); end
  endtask

  task automatic test_random();
    logic cs, ia, rw;
    logic [2:0] a;
    logic [7:0] d;
    int r;
    for (int n = 0; n < 150; n++) begin
      r  = $urandom_range(0, 9);
      cs = 1'b1; ia = 1'b1; rw = 1'b1;
      a  = 3'($urandom_range(0, 7));
      d  = 8'($urandom_range(0, 255));
      if (r == 0) begin
        ia = 1'b0; cs = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1));
      end else if (r >= 3) begin
        cs = 1'b0; rw = 1'($urandom_range(0, 1));
      end
      if (!rw && a == ADR_RELOAD_HI) d = 8'($urandom_range(0, 1));
      if (!rw && a == ADR_CTRL) d[0] = 1'b1;
      bus_cycle(cs, ia, rw, a, d);
      checks++; if (obs_oe_idle !== 1'b0) begin errors++; $display("FAIL rnd_oe_elow n=%0d got %b exp 0", n, obs_oe_idle); end
      checks++; if (obs_oe !== exp_oe) begin errors++; $display("FAIL rnd_oe n=%0d got %b exp %b", n, obs_oe, exp_oe); end
      if (exp_oe) begin
        checks++; if (obs_dout !== exp_dout) begin errors++; $display("FAIL rnd_data n=%0d adr=%0d got %h exp %h", n, a, obs_dout, exp_dout); end
      end
      checks++; if (obs_irq !== exp_irq) begin errors++; $display("FAIL rnd_irq n=%0d got %b exp %b", n, obs_irq, exp_irq); end
      checks++; if (obs_mrdy_low !== exp_mrdy_low) begin errors++; $display("FAIL rnd_mrdy n=%0d got %0d exp %0d", n, obs_mrdy_low, exp_mrdy_low); end
      checks++; if (obs_mrdy0_low !== 0) begin errors++; $display("FAIL rnd_mrdy0 n=%0d got %0d exp 0", n, obs_mrdy0_low); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_timer();
    test_iack();
    test_collision();
    test_wait();
    test_snapshot();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/m6809_io_responder.md
Name: m6809_io_responder

Overview:
- Expansion-card target that answers the CPU card's `csio_b` / `iack_b` / `rnw` / E-clock bus cycles.
- Holds a small register file, a 16-bit interval timer that drives `irq_b`, and a programmable interrupt vector byte returned during IACK cycles.
- Drives `sys_mrdy` low to stretch slow accesses.
- Sits on the system side of the expansion port, opposite the CPU card's decode/clock CPLD.

Parameters:
- WAIT_CLKS, 2, number of `clkin` cycles `sys_mrdy` is held low per `csio_b` access (0 = no stretch).
- RESET_VECTOR, 8'hF0, reset value of the VECTOR register.

Ports:
- clkin  input  1  board clock, 4x E frequency; all logic on its rising edge.
- rst_b  input  1  asynchronous active-low reset.
- eclk  input  1  CPU E clock from card.
- csio_b  input  1  active-low I/O page select.
- iack_b  input  1  active-low interrupt-acknowledge cycle.
- rnw  input  1  1 = read, 0 = write.
- adr  input  3  register offset, `adr[2:0]`.
- data_in  input  8  CPU write data.
- data_out  output  8  read / vector data.
- data_oe  output  1  enable for the external data-bus driver.
- sys_mrdy  output  1  memory ready; 0 stretches the cycle.
- irq_b  output  1  active-low interrupt request; open-drain intent, driven 0/1 here.

Behaviour:
- Reset (async, `rst_b` = 0) sets:
  - `data_out` = 0, `data_oe` = 0, `sys_mrdy` = 1, `irq_b` = 1
  - CTRL = 0, FLAG = 0, RELOAD = 16'hFFFF, COUNT = 16'hFFFF, VECTOR = RESET_VECTOR
  - wait FSM in IDLE.
- Edge detection: `eclk` is registered as `e_q`.
  - `e_rise` = `eclk` & !`e_q`.
  - `e_fall` = !`eclk` & `e_q`.
- Register map (`adr`):
  - 0 CTRL: bit0 EN, bit1 IE.
  - 1 STATUS: bit0 FLAG; writing a 1 clears it, writing 0 has no effect.
  - 2 RELOAD_LO.
  - 3 RELOAD_HI.
  - 4 COUNT_LO, read-only.
  - 5 COUNT_HI, read-only.
  - 6 VECTOR.
  - 7 reserved: reads 0, writes ignored.
- Read path:
  - While `csio_b` = 0, `rnw` = 1 and `eclk` = 1, `data_oe` = 1 and `data_out` = the selected register, registered one `clkin` after the condition.
  - `data_oe` drops in the cycle after `eclk` falls.
- Write path: committed on `e_fall` when `csio_b` = 0 and `rnw` = 0. Writes are never committed mid-E.
- IACK:
  - While `iack_b` = 0 and `eclk` = 1, `data_oe` = 1 and `data_out` = VECTOR.
  - On `e_fall` with `iack_b` = 0, FLAG is cleared.
  - If `csio_b` and `iack_b` are both low, IACK wins and the register access is ignored.
- Timer:
  - Acts on `e_fall` when EN = 1.
  - If COUNT = 0: reload COUNT from RELOAD and set FLAG. Otherwise decrement COUNT.
  - RELOAD = 0 therefore sets FLAG every E cycle.
  - Writing RELOAD_HI also loads COUNT with {data_in, RELOAD_LO}.
  - EN 0->1 does not reload; counting resumes from the current COUNT.
- `irq_b` = !(FLAG & IE), registered.
- Simultaneous events on the same `e_fall`:
  - A FLAG set from underflow beats a clear from the STATUS write or from IACK.
  - A CTRL write and an underflow both take effect.
- Wait FSM, states IDLE -> STRETCH -> HOLD:
  - IDLE -> STRETCH: on `csio_b` falling while `eclk` = 0, with WAIT_CLKS > 0. Sets `sys_mrdy` = 0 and loads the counter with WAIT_CLKS.
  - STRETCH: decrements each `clkin`. At 1, `sys_mrdy` returns to 1 and the FSM goes to HOLD.
  - HOLD -> IDLE: when `csio_b` = 1.
  - WAIT_CLKS = 0 keeps `sys_mrdy` = 1 permanently.
  - `csio_b` deasserting during STRETCH aborts to IDLE with `sys_mrdy` = 1.
  - IACK cycles are never stretched.
- Reset mid-access: outputs return to reset values immediately; there is no partial write.

Optional Feature:
- Macro: M6809_IORESP_SNAPSHOT_EN.
- Defined:
  - A read of COUNT_LO latches COUNT[15:8] into a snapshot register.
  - A subsequent COUNT_HI read returns the snapshot, giving a coherent 16-bit read across two accesses.
  - Reset clears the snapshot to 0.
- Undefined:
  - COUNT_HI returns the live COUNT[15:8].
  - No snapshot register exists.

Decomposition:
- Shared package `m6809_io_pkg` holds:
  - register offset constants (CTRL, STATUS, RELOAD_LO, RELOAD_HI, COUNT_LO, COUNT_HI, VECTOR)
  - CTRL bit indices
  - wait FSM state encoding (IDLE = 2'b00, STRETCH = 2'b01, HOLD = 2'b10).
- One sub-module is natural: `m6809_io_timer`, containing the COUNT/RELOAD down-counter, the FLAG logic and the optional snapshot. The top module keeps decode, the data mux and the wait FSM.

Test Plan:
- Reset: assert `rst_b` = 0 mid-write -> all outputs at reset values, CTRL = 0, VECTOR = 8'hF0; writes issued after release are accepted.
- Timer: write RELOAD_LO = 8'h03, RELOAD_HI = 8'h00, CTRL = 8'h03 -> FLAG sets, and `irq_b` goes to 0, on the 4th `e_fall` after enable; reload repeats every 4 E cycles.
- IACK: with FLAG set and VECTOR = 8'h5A, drive `iack_b` low for one E cycle -> `data_oe` = 1, `data_out` = 8'h5A; `irq_b` returns to 1 after `e_fall`.
- Collision: STATUS write 8'h01 coincident with an underflow `e_fall` -> FLAG stays 1 and `irq_b` stays 0.
- Wait states (WAIT_CLKS = 2): `csio_b` falls in the E-low phase -> `sys_mrdy` = 0 for exactly 2 `clkin` cycles; with WAIT_CLKS = 0, `sys_mrdy` never drops.
- Snapshot, with the macro defined: COUNT = 16'h01FF, read COUNT_LO, then let the counter roll to 16'h00FE before reading COUNT_HI -> 8'h01 is returned; without the macro, 8'h00.
